// File: rtl/regfile_mux_param.sv
// Multi-port register file: one synchronous write port, NREAD registered read ports, entry 0 reads zero.
// Build option: define REGFILE_BYPASS_EN for write-first collisions; otherwise reads on a collision return the old value.
module regfile_mux_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    output logic [NREAD-1:0]        rd_valid
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [NREAD*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NREAD-1:0]       rd_valid_q, rd_valid_d;
    logic                   wr_hit;

    function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < DEPTH_C);
    endfunction

    always_comb begin
        wr_hit = wr_en && addr_live(wr_addr);
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[IDX_W'(wr_addr)] = wr_data;
        end
        mem_d[0] = '0;
    end

    always_comb begin : read_sel
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  sel;
        ra         = '0;
        sel        = '0;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        for (int p = 0; p < NREAD; p++) begin
            ra  = rd_addr[p*ADDR_W +: ADDR_W];
            sel = '0;
            if (addr_live(ra)) begin
                sel = mem_q[IDX_W'(ra)];
`ifdef REGFILE_BYPASS_EN
                if (wr_hit && (ra == wr_addr)) begin
                    sel = wr_data;
                end
`endif
            end
            if (rd_en[p]) begin
                rd_valid_d[p]                = 1'b1;
                rd_data_d[p*WIDTH +: WIDTH]  = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
